// File: rtl/rockband_pkg.sv
// Shared types and constants for the Rock Band controller front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rockband_pkg;

    // Per-lane debounce FSM states; level is 1 in HELD and RELEASE_WAIT.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } fret_state_t;

    // Five fret buttons: green, red, yellow, blue, orange.
    localparam int NUM_FRETS = 5;

    // System clock frequency; 500000 debounce cycles is 10 ms at this rate.
    localparam int CLK_HZ = 50_000_000;

endpackage

// File: rtl/fret_debounce_lane.sv
// One button lane: 2-flop synchroniser, stability counter and debounce FSM.
// Latency: level/pulse change DEBOUNCE_CYCLES+2 edges after the first sampling edge.
// Backpressure: none; free-running, pulses are single-cycle and unacknowledged.
module fret_debounce_lane
    import rockband_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_p
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    fret_state_t   state;
    fret_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;

    // Two-stage synchroniser; only sync_b is used by the FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // State, counter and edge pulses registered together so a pulse lands on the new level's first cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
        end
    end

    // Next state: any reversal during a wait restarts from scratch; the counter exits at CNT_LAST so it never wraps.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sync_b) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_b) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!sync_b) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_b) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level     = (state == HELD) || (state == RELEASE_WAIT);
    assign press     = press_q;
    assign release_p = release_q;

endmodule

// File: rtl/fret_debounce.sv
// Fret/strum input conditioner: per-lane debounced level plus press/release pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sample to output; ORs add no cycle.
// Backpressure: none; outputs are free-running registered levels and pulses.
module fret_debounce
    import rockband_pkg::*;
#(
    parameter int LANES           = NUM_FRETS,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [LANES-1:0] btn_raw,
    output logic [LANES-1:0] fret_level,
    output logic [LANES-1:0] press_pulse,
    output logic [LANES-1:0] release_pulse,
    output logic             press_load,
    output logic             any_held
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fret_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .Clk      (Clk),
            .Reset    (Reset),
            .btn_raw  (btn_raw[g]),
            .level    (fret_level[g]),
            .press    (press_pulse[g]),
            .release_p(release_pulse[g])
        );
    end

    // Shared "any note attempted" load and hold indicator, straight from registered lane bits.
    assign press_load = |press_pulse;
    assign any_held   = |fret_level;

endmodule

// File: tb/tb_fret_debounce.sv
// Directed bench for fret_debounce with a run-length reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_fret_debounce;

    localparam int L = 5;
    localparam int D = 4;

    logic         Clk;
    logic         Reset;
    logic [L-1:0] btn_raw;
    logic [L-1:0] fret_level;
    logic [L-1:0] press_pulse;
    logic [L-1:0] release_pulse;
    logic         press_load;
    logic         any_held;

    int tests = 0;
    int fails = 0;

    fret_debounce #(.LANES(L), .DEBOUNCE_CYCLES(D)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .btn_raw      (btn_raw),
        .fret_level   (fret_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_load   (press_load),
        .any_held     (any_held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a lane flips level once its synchronised input has disagreed with
    // the level on D+1 consecutive edges; any agreement clears the run.
    bit [L-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl;
    int         m_run [L];
    bit         started = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pr = '0; m_rl = '0;
            for (int i = 0; i < L; i++) m_run[i] = 0;
            started = 1'b1;
        end else begin
            m_pr = '0;
            m_rl = '0;
            for (int i = 0; i < L; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        if (m_lvl[i]) m_rl[i] = 1'b1;
                        else          m_pr[i] = 1'b1;
                        m_lvl[i]  = ~m_lvl[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
        #1;
        if (started) begin
            chk("model_level",   32'(fret_level),    32'(m_lvl));
            chk("model_press",   32'(press_pulse),   32'(m_pr));
            chk("model_release", 32'(release_pulse), 32'(m_rl));
            chk("model_load",    32'(press_load),    32'(|m_pr));
            chk("model_held",    32'(any_held),      32'(|m_lvl));
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        btn_raw = '0;
        tick(3);
        chk("reset_level", 32'(fret_level), 32'h0);
        chk("reset_load",  32'(press_load), 32'h0);
        chk("reset_held",  32'(any_held),   32'h0);
        Reset = 1'b0;

        // Idle: nothing moves for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("idle_outs", {press_load, any_held, release_pulse, press_pulse, fret_level}, 32'h0);
        end

        // Clean press on lane 0; next edge is edge 0.
        btn_raw[0] = 1'b1;
        tick(6);
        chk("press_e5_level", 32'(fret_level), 32'h00);
        tick(1);
        chk("press_e6_level", 32'(fret_level),  32'h01);
        chk("press_e6_pulse", 32'(press_pulse), 32'h01);
        chk("press_e6_load",  32'(press_load),  32'h1);
        tick(1);
        chk("press_e7_pulse", 32'(press_pulse), 32'h00);
        chk("press_e7_level", 32'(fret_level),  32'h01);
        tick(12);
        btn_raw[0] = 1'b0;
        tick(6);
        chk("rel_e25_level", 32'(fret_level),    32'h01);
        chk("rel_e25_pulse", 32'(release_pulse), 32'h00);
        tick(1);
        chk("rel_e26_pulse", 32'(release_pulse), 32'h01);
        chk("rel_e26_level", 32'(fret_level),    32'h00);
        tick(1);
        chk("rel_e27_pulse", 32'(release_pulse), 32'h00);
        tick(5);

        // Lane 2 high for 3 cycles only: rejected.
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("glitch_outs", {press_load, any_held, press_pulse, fret_level}, 32'h0);
        end

        // Bounce 1,1,0,1,1,...: press 6 edges after the last rising sample.
        btn_raw[2] = 1'b1;
        tick(2);
        btn_raw[2] = 1'b0;
        tick(1);
        btn_raw[2] = 1'b1;
        tick(6);
        chk("bounce_e5_pulse", 32'(press_pulse), 32'h00);
        tick(1);
        chk("bounce_e6_pulse", 32'(press_pulse), 32'h04);
        btn_raw[2] = 1'b0;
        tick(10);

        // Simultaneous lanes 0, 2, 4.
        btn_raw = 5'b10101;
        tick(6);
        chk("simul_e5_pulse", 32'(press_pulse), 32'h00);
        tick(1);
        chk("simul_e6_pulse", 32'(press_pulse), 32'h15);
        chk("simul_e6_load",  32'(press_load),  32'h1);
        chk("simul_e6_held",  32'(any_held),    32'h1);
        chk("simul_e6_level", 32'(fret_level),  32'h15);
        btn_raw = '0;
        tick(10);

        // Reset while lane 1 is held, button stays down throughout.
        btn_raw[1] = 1'b1;
        tick(8);
        chk("rst_pre_level", 32'(fret_level), 32'h02);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("rst_level",   32'(fret_level),    32'h00);
        chk("rst_release", 32'(release_pulse), 32'h00);
        tick(6);
        chk("rst_e5_pulse", 32'(press_pulse), 32'h00);
        tick(1);
        chk("rst_e6_pulse", 32'(press_pulse), 32'h02);
        btn_raw[1] = 1'b0;
        tick(10);

        // Lane 3 held, then a 2-cycle release glitch.
        btn_raw[3] = 1'b1;
        tick(8);
        btn_raw[3] = 1'b0;
        tick(2);
        btn_raw[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("relglitch_level", 32'(fret_level),    32'h08);
            chk("relglitch_pulse", 32'(release_pulse), 32'h00);
        end
        btn_raw = '0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
